tick_rate_ctrl: RTL

Runtime-configurable controller for the game's clock-division resource. Produces a divided 50%-duty clock (O_CLK) and a one-cycle tick enable (O_TICK) from I_CLK. Sequences start/stop/single-step of the divider and accepts new division ratios through a valid/ready handshake. New ratios and stops take effect only at period boundaries, so downstream game and VGA logic never sees a truncated period.

---
 rtl/tick_rate_pkg.sv | 14 +
 rtl/tick_rate_ctrl_period_counter.sv | 40 ++++
 rtl/tick_rate_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/tick_rate_pkg.sv
// Shared state encoding and divisor limits for the tick rate controller.
package tick_rate_pkg;

  typedef enum logic [1:0] {
    STOP,
    RUN,
    SWITCH,
    STEP
  } tick_state_t;

  localparam int unsigned DEFAULT_DIV = 20;
  localparam int unsigned MIN_DIV     = 2;

endpackage

// File: rtl/tick_rate_ctrl_period_counter.sv
// Period counter: counts 0..div-1 while active, flags the wrap, and
// produces the registered divided clock and the post-wrap tick pulse.
module period_counter #(
  parameter int WIDTH = 16
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             active,
  input  logic [WIDTH-1:0] div,
  output logic             wrap,
  output logic             clk_out,
  output logic             tick
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    wrap       = active && (count == div - WIDTH'(1));
    count_next = '0;
    if (active && !wrap) begin
      count_next = count + WIDTH'(1);
    end
  end

  // Phase is judged on the next count so clk_out lines up with count itself;
  // an odd divisor leaves the extra cycle in the high phase.
  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      count   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      count   <= count_next;
      clk_out <= active && (count_next >= (div >> 1));
      tick    <= wrap;
    end
  end

endmodule

// File: rtl/tick_rate_ctrl.sv
// Clock-division controller: run/stop/single-step sequencing plus a
// valid/ready divisor port whose updates land only on period boundaries.
module tick_rate_ctrl #(
  parameter int          WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = tick_rate_pkg::DEFAULT_DIV,
  parameter int unsigned MIN_DIV     = tick_rate_pkg::MIN_DIV
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             O_CLK,
  output logic             O_TICK,
  output logic [WIDTH-1:0] cur_div,
  output logic             busy
);

  import tick_rate_pkg::*;

  tick_state_t      state;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] pend_div;
  logic             wrap;
  logic             cfg_take;
  logic             cfg_bad;
  logic             cfg_legal;

  assign cfg_ready = (state == STOP) || (state == RUN);
  assign busy      = (state != STOP);
  assign cur_div   = div_reg;
  assign cfg_take  = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_div < WIDTH'(MIN_DIV));
  assign cfg_legal = cfg_take && !cfg_bad;

  period_counter #(.WIDTH(WIDTH)) u_period_counter (
    .I_CLK   (I_CLK),
    .rst     (rst),
    .active  (busy),
    .div     (div_reg),
    .wrap    (wrap),
    .clk_out (O_CLK),
    .tick    (O_TICK)
  );

  // A legal divisor that arrives on a stopping wrap is applied directly,
  // since no later boundary will come to pick it up from pend_div.
  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      state    <= STOP;
      div_reg  <= WIDTH'(DEFAULT_DIV);
      pend_div <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_take && cfg_bad;
      case (state)
        STOP: begin
          if (cfg_legal) begin
            div_reg <= cfg_div;
          end
          if (en) begin
            state <= RUN;
          end else if (step) begin
            state <= STEP;
          end
        end
        RUN: begin
          if (wrap && !en) begin
            state <= STOP;
            if (cfg_legal) begin
              div_reg <= cfg_div;
            end
          end else if (cfg_legal) begin
            pend_div <= cfg_div;
            state    <= SWITCH;
          end
        end
        SWITCH: begin
          if (wrap) begin
            div_reg <= pend_div;
            state   <= en ? RUN : STOP;
          end
        end
        STEP: begin
          if (wrap) begin
            state <= en ? RUN : STOP;
          end
        end
        default: state <= STOP;
      endcase
    end
  end

endmodule
